// File: rtl/enc_pkg.sv
// Shared constants and state encoding for the request encoder
// and the arbiter blocks that will reuse it.
package enc_pkg;

  localparam int REQ_N = 8;
  localparam int REQ_W = $clog2(REQ_N);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/req_enc_seq_lsb_idx.sv
// Lowest-set-bit index of a vector plus an "exactly one bit set" flag.
// The index reads 0 when the vector is empty.
module lsb_idx #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_one
);

  logic [N-1:0] w_rest;

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

  assign w_rest = i_vec & (i_vec - N'(1));
  assign o_one  = (i_vec != '0) && (w_rest == '0);

endmodule

// File: rtl/req_enc_seq.sv
// Captures a request vector and emits the index of every set bit,
// lowest first, one per out_valid/out_ready handshake.
module req_enc_seq
  import enc_pkg::*;
#(
  parameter int N = REQ_N,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  input  logic         out_ready,
  output logic         zero_err
);

  state_t       r_state;
  logic [N-1:0] r_pending;
  logic         r_zero_err;
  logic [W-1:0] w_idx;
  logic         w_one;

  lsb_idx #(.N(N)) u_lsb (
    .i_vec (r_pending),
    .o_idx (w_idx),
    .o_one (w_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (in_req != '0) begin
              r_pending <= in_req;
              r_state   <= EMIT;
            end else begin
              r_zero_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          // Clearing the lowest set bit advances to the next index.
          if (out_ready) begin
            r_pending <= r_pending & (r_pending - N'(1));
            if (w_one) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == EMIT);
  assign out_idx   = w_idx;
  assign out_last  = out_valid & w_one;
  assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_req_enc_seq.sv
// Directed-vector bench for req_enc_seq.
module tb_req_enc_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_req;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_ready;
  logic       zero_err;

  int passed;
  int total;

  req_enc_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_req    (in_req),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_req = 8'h00;
    out_ready = 1'b0;
    #2;
    tick();
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0)
      $display("FAIL rst_out got v=%b l=%b exp 0 0", out_valid, out_last);
    else passed++;
    total++;
    if (zero_err !== 1'b0 || out_idx !== 3'd0)
      $display("FAIL rst_misc got ze=%b idx=%0d exp 0 0", zero_err, out_idx);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_req = 8'b0000_0001;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL single_beat got v=%b idx=%0d l=%b r=%b exp 1 0 1 0",
               out_valid, out_idx, out_last, in_ready);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL single_after got v=%b r=%b exp 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_multi();
    logic [2:0] exp_idx [4];
    logic [7:0] acc;
    exp_idx[0] = 3'd1;
    exp_idx[1] = 3'd2;
    exp_idx[2] = 3'd5;
    exp_idx[3] = 3'd7;
    acc = 8'h00;
    in_valid = 1'b1;
    in_req = 8'b1010_0110;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== exp_idx[i] || out_last !== (i == 3))
        $display("FAIL multi_beat%0d got v=%b idx=%0d l=%b exp 1 %0d %b",
                 i, out_valid, out_idx, out_last, exp_idx[i], (i == 3));
      else passed++;
      acc = acc | (8'h01 << out_idx);
      tick();
    end
    total++;
    if (acc !== 8'hA6)
      $display("FAIL multi_or got=%h exp=a6", acc);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL multi_after got v=%b r=%b exp 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_toggle();
    int c;
    int exp_i;
    c = 0;
    exp_i = 0;
    in_valid = 1'b1;
    in_req = 8'hFF;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    while (exp_i < 8 && c < 40) begin
      out_ready = (c % 2 == 0);
      total++;
      if (out_valid !== 1'b1 || out_idx !== exp_i[2:0] || out_last !== (exp_i == 7))
        $display("FAIL toggle_c%0d got v=%b idx=%0d l=%b exp 1 %0d %b",
                 c, out_valid, out_idx, out_last, exp_i, (exp_i == 7));
      else passed++;
      if (out_ready) exp_i++;
      tick();
      c++;
    end
    out_ready = 1'b0;
    total++;
    if (c !== 15)
      $display("FAIL toggle_cycles got=%0d exp=15", c);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL toggle_after got v=%b r=%b exp 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_zero();
    in_valid = 1'b1;
    in_req = 8'h00;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (zero_err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL zero_pulse got ze=%b r=%b v=%b exp 1 1 0",
               zero_err, in_ready, out_valid);
    else passed++;
    tick();
    total++;
    if (zero_err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL zero_clear got ze=%b v=%b exp 0 0", zero_err, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen7;
    seen7 = 0;
    in_valid = 1'b1;
    in_req = 8'h81;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0)
      $display("FAIL rmid_first got v=%b idx=%0d exp 1 0", out_valid, out_idx);
    else passed++;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7)
      $display("FAIL rmid_second got v=%b idx=%0d exp 1 7", out_valid, out_idx);
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rmid_async got v=%b r=%b exp 0 1", out_valid, in_ready);
    else passed++;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid === 1'b1) seen7++;
    end
    total++;
    if (seen7 !== 0 || in_ready !== 1'b1)
      $display("FAIL rmid_replay got beats=%0d r=%b exp 0 1", seen7, in_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_req = 8'h03;
    out_ready = 1'b1;
    tick();
    in_req = 8'h10;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || in_ready !== 1'b0)
      $display("FAIL b2b_idx0 got v=%b idx=%0d r=%b exp 1 0 0",
               out_valid, out_idx, in_ready);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b1)
      $display("FAIL b2b_idx1 got v=%b idx=%0d l=%b exp 1 1 1",
               out_valid, out_idx, out_last);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_idle got v=%b r=%b exp 0 1", out_valid, in_ready);
    else passed++;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1)
      $display("FAIL b2b_idx4 got v=%b idx=%0d l=%b exp 1 4 1",
               out_valid, out_idx, out_last);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_after got v=%b r=%b exp 0 1", out_valid, in_ready);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_single();
    test_multi();
    test_toggle();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
